chip8_sprite_draw: RTL and testbench

CHIP8_SPRITE_DRAW -- requirements
Module: chip8_sprite_draw

---
 rtl/chip8_sprite_draw.sv | 144 ++++++++++++++
 tb/tb_chip8_sprite_draw.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite blitter: XORs up to 15 sprite rows into a 64x32 framebuffer, reporting VF collision.
// Define CHIP8_SPRITE_CLIP_EN to clip rows/pixels past the screen edge instead of wrapping them.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; latches coordinates, height and sprite base
// ST_FETCH | presents sprite byte address and framebuffer row address
// ST_WAIT  | holds both addresses while the synchronous memories respond
// ST_WRITE | XORs the shifted sprite byte into the row, updates collision
// ST_DONE  | one-cycle completion pulse, then back to idle

module chip8_sprite_draw (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  vx,
    input  logic [7:0]  vy,
    input  logic [3:0]  n,
    input  logic [11:0] i_addr,
    output logic [11:0] ram_read_address,
    input  logic [7:0]  ram_q,
    output logic [4:0]  fb_row_address,
    input  logic [63:0] fb_row_q,
    output logic [63:0] fb_row_d,
    output logic        fb_we,
    output logic        busy,
    output logic        done,
    output logic        collision
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_x;
    logic [4:0]  r_y;
    logic [3:0]  r_n;
    logic [11:0] r_base;
    logic [3:0]  r_k;
    logic        r_collision;

    logic        w_load;
    logic        w_advance;
    logic        w_coll_set;
    logic [4:0]  w_k_next;
    logic [63:0] w_spr;
    logic [63:0] w_mask_raw;
    logic [63:0] w_mask;
    logic        w_row_skip;
    logic        w_unused_bits;

    assign w_unused_bits = &{1'b0, vx[7:6], vy[7:5]};

    // Both addresses come straight from registers, so they stay put through WAIT.
    assign ram_read_address = r_base + {8'd0, r_k};
    assign fb_row_address   = r_y + {1'b0, r_k};
    assign busy             = (r_state != ST_IDLE);
    assign collision        = r_collision;
    assign w_k_next         = {1'b0, r_k} + 5'd1;

    // Sprite bit 7 sits at fb bit 63 (column 0) before shifting right by x.
    assign w_spr = {ram_q, 56'd0};

`ifdef CHIP8_SPRITE_CLIP_EN
    logic [5:0] w_row_sum;
    assign w_row_sum  = {1'b0, r_y} + {2'b00, r_k};
    assign w_row_skip = w_row_sum[5];
    assign w_mask_raw = w_spr >> r_x;
`else
    logic [6:0] w_lsh;
    assign w_lsh      = 7'd64 - {1'b0, r_x};
    assign w_row_skip = 1'b0;
    assign w_mask_raw = (w_spr >> r_x) | (w_spr << w_lsh);
`endif

    assign w_mask = w_row_skip ? 64'd0 : w_mask_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_x         <= 6'd0;
            r_y         <= 5'd0;
            r_n         <= 4'd0;
            r_base      <= 12'd0;
            r_k         <= 4'd0;
            r_collision <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_x         <= vx[5:0];
                r_y         <= vy[4:0];
                r_n         <= n;
                r_base      <= i_addr;
                r_k         <= 4'd0;
                r_collision <= 1'b0;
            end
            if (w_advance) begin
                r_k <= w_k_next[3:0];
            end
            if (w_coll_set) begin
                r_collision <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_advance  = 1'b0;
        w_coll_set = 1'b0;
        fb_row_d   = 64'd0;
        fb_we      = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = (n == 4'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: w_next = ST_WAIT;
            ST_WAIT:  w_next = ST_WRITE;
            ST_WRITE: begin
                fb_row_d   = fb_row_q ^ w_mask;
                fb_we      = ~w_row_skip;
                w_coll_set = |(fb_row_q & w_mask);
                w_advance  = 1'b1;
                w_next     = (w_k_next < {1'b0, r_n}) ? ST_FETCH : ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Self-checking bench for chip8_sprite_draw: behavioural RAM/framebuffer, pixel-level model, write scoreboard.
// Build with +define+CHIP8_SPRITE_CLIP_EN to check the clipping variant.

module tb_chip8_sprite_draw;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic [11:0] ram_read_address;
    logic [7:0]  ram_q;
    logic [4:0]  fb_row_address;
    logic [63:0] fb_row_q;
    logic [63:0] fb_row_d;
    logic        fb_we;
    logic        busy;
    logic        done;
    logic        collision;

    chip8_sprite_draw dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .vx               (vx),
        .vy               (vy),
        .n                (n),
        .i_addr           (i_addr),
        .ram_read_address (ram_read_address),
        .ram_q            (ram_q),
        .fb_row_address   (fb_row_address),
        .fb_row_q         (fb_row_q),
        .fb_row_d         (fb_row_d),
        .fb_we            (fb_we),
        .busy             (busy),
        .done             (done),
        .collision        (collision)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [4096];
    logic [63:0] fb  [32];

    always @(posedge clk) begin
        ram_q    <= ram[ram_read_address];
        fb_row_q <= fb[fb_row_address];
        if (reset) begin
            for (int i = 0; i < 32; i++) fb[i] <= 64'd0;
        end else if (fb_we) begin
            fb[fb_row_address] <= fb_row_d;
        end
    end

    typedef struct {
        logic [4:0]  row;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  vx;
        logic [7:0]  vy;
        logic [3:0]  n;
        logic [11:0] addr;
        int          exp_done;
        int          exp_wr;
    } vec_t;

    wr_t         sb [$];
    vec_t        vt [5];
    logic [63:0] m_fb [32];
    logic [63:0] last_d;
    logic        exp_coll;
    int          n_wr;
    int          cur_n;
    int          cur_y;
    int          cur_a;
    int          n_err = 0;
    int          n_chk = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Column c of the screen is fb bit 63-c; sprite bit b lands on column x+7-b.
    function automatic logic [63:0] model_mask(input logic [5:0] x, input logic [7:0] byt);
        logic [63:0] m;
        int col;
        m = 64'd0;
        for (int b = 0; b < 8; b++) begin
            col = int'(x) + 7 - b;
`ifdef CHIP8_SPRITE_CLIP_EN
            if (col < 64 && byt[3'(b)]) m[6'(63 - col)] = 1'b1;
`else
            if (byt[3'(b)]) m[6'(63 - (col % 64))] = 1'b1;
`endif
        end
        return m;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_fb[i] = 64'd0;
        sb.delete();
    endtask

    task automatic launch(input logic [7:0] ivx, input logic [7:0] ivy,
                          input logic [3:0] in, input logic [11:0] ia);
        logic [63:0] msk;
        logic [11:0] ai;
        logic [4:0]  ri;
        logic        skip;
        wr_t         e;
        int          r;
        exp_coll = 1'b0;
        cur_n    = int'(in);
        cur_y    = int'(ivy[4:0]);
        cur_a    = int'(ia);
        for (int k = 0; k < cur_n; k++) begin
            r   = cur_y + k;
            ai  = 12'((cur_a + k) % 4096);
            msk = model_mask(ivx[5:0], ram[ai]);
`ifdef CHIP8_SPRITE_CLIP_EN
            skip = (r >= 32);
`else
            skip = 1'b0;
`endif
            if (!skip) begin
                ri = 5'(r % 32);
                if ((m_fb[ri] & msk) != 64'd0) exp_coll = 1'b1;
                e.row  = ri;
                e.data = m_fb[ri] ^ msk;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        start  = 1'b1;
        vx     = ivx;
        vy     = ivy;
        n      = in;
        i_addr = ia;
        @(posedge clk);
    endtask

    task automatic take_write(input int cyc);
        wr_t e;
        check("we_in_write_slot", 64'(cyc % 3), 64'd0);
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_we: actual row=%0d data=%h required=no write", fb_row_address, fb_row_d);
        end else begin
            e = sb.pop_front();
            check("we_row", 64'(fb_row_address), 64'(e.row));
            check("we_data", fb_row_d, e.data);
            m_fb[e.row] = e.data;
        end
        last_d = fb_row_d;
        n_wr++;
    endtask

    task automatic finish_draw(input int exp_done, input bit hold);
        int seen;
        int k;
        seen = 0;
        n_wr = 0;
        for (int cyc = 1; cyc <= 64 && seen == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("busy_running", 64'(busy), 64'd1);
            if (fb_we) take_write(cyc);
            if (cyc % 3 == 1 && (cyc - 1) / 3 < cur_n) begin
                k = (cyc - 1) / 3;
                check("ram_addr", 64'(ram_read_address), 64'((cur_a + k) % 4096));
                check("fb_addr", 64'(fb_row_address), 64'((cur_y + k) % 32));
            end
            if (done) begin
                seen = cyc;
                check("done_cycle", 64'(cyc), 64'(exp_done));
                check("collision", 64'(collision), 64'(exp_coll));
            end
            start = hold && !done;
            if (hold) begin
                vx     = 8'h00;
                vy     = 8'h00;
                n      = 4'hF;
                i_addr = 12'h000;
            end
        end
        if (seen == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: actual=no done required=cycle %0d", exp_done);
        end
        check("queue_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_one_cycle", 64'(done), 64'd0);
        check("collision_hold", 64'(collision), 64'(exp_coll));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        vx     = 8'h00;
        vy     = 8'h00;
        n      = 4'h0;
        i_addr = 12'h000;
        last_d = 64'd0;
        clear_model();
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h100] = 8'hF0;
        ram[12'h110] = 8'hFF;
        ram[12'h120] = 8'h81;
        ram[12'h121] = 8'h42;
        ram[12'h122] = 8'h24;
        ram[12'h123] = 8'h18;
        ram[12'hFFF] = 8'hA5;
        ram[12'h000] = 8'h3C;

        vt[0] = '{vx: 8'h05, vy: 8'h02, n: 4'd3,  addr: 12'h200, exp_done: 10, exp_wr: 3};
        vt[1] = '{vx: 8'hC5, vy: 8'hE2, n: 4'd3,  addr: 12'h200, exp_done: 10, exp_wr: 3};
        vt[3] = '{vx: 8'h20, vy: 8'h10, n: 4'd8,  addr: 12'h400, exp_done: 25, exp_wr: 8};
`ifdef CHIP8_SPRITE_CLIP_EN
        vt[2] = '{vx: 8'h3C, vy: 8'h1C, n: 4'd15, addr: 12'h300, exp_done: 46, exp_wr: 4};
        vt[4] = '{vx: 8'h01, vy: 8'h1F, n: 4'd2,  addr: 12'hFFE, exp_done: 7,  exp_wr: 1};
`else
        vt[2] = '{vx: 8'h3C, vy: 8'h1C, n: 4'd15, addr: 12'h300, exp_done: 46, exp_wr: 15};
        vt[4] = '{vx: 8'h01, vy: 8'h1F, n: 4'd2,  addr: 12'hFFE, exp_done: 7,  exp_wr: 2};
`endif

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(fb_we), 64'd0);
        check("rst_collision", 64'(collision), 64'd0);
        check("rst_ram_addr", 64'(ram_read_address), 64'd0);
        check("rst_fb_addr", 64'(fb_row_address), 64'd0);
        check("rst_fb_d", fb_row_d, 64'd0);
        reset = 1'b0;

        launch(8'd0, 8'd0, 4'd1, 12'h100);
        finish_draw(4, 1'b0);
        check("f0_row", last_d, 64'hF000_0000_0000_0000);
        check("f0_writes", 64'(n_wr), 64'd1);
        check("f0_coll", 64'(collision), 64'd0);

        launch(8'd0, 8'd0, 4'd1, 12'h100);
        finish_draw(4, 1'b0);
        check("f0_again_row", last_d, 64'd0);
        check("f0_again_coll", 64'(collision), 64'd1);

        // x=62: columns 62,63 -> bits 1,0; wrapped columns 0..5 -> bits 63..58
        launch(8'd62, 8'd3, 4'd1, 12'h110);
        finish_draw(4, 1'b0);
`ifdef CHIP8_SPRITE_CLIP_EN
        check("x62_row", last_d, 64'h0000_0000_0000_0003);
`else
        check("x62_row", last_d, 64'hFC00_0000_0000_0003);
`endif

        launch(8'd10, 8'd30, 4'd4, 12'h120);
        finish_draw(13, 1'b0);
`ifdef CHIP8_SPRITE_CLIP_EN
        check("y30_writes", 64'(n_wr), 64'd2);
`else
        check("y30_writes", 64'(n_wr), 64'd4);
`endif

        launch(8'd5, 8'd5, 4'd0, 12'h130);
        finish_draw(1, 1'b0);
        check("n0_writes", 64'(n_wr), 64'd0);
        check("n0_coll", 64'(collision), 64'd0);

        for (int i = 0; i < 5; i++) begin
            launch(vt[i].vx, vt[i].vy, vt[i].n, vt[i].addr);
            finish_draw(vt[i].exp_done, 1'b0);
            check("tbl_writes", 64'(n_wr), 64'(vt[i].exp_wr));
        end

        // Abort during the second WAIT (cycle 5) of a five-row draw.
        launch(8'd8, 8'd4, 4'd5, 12'h500);
        n_wr = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (fb_we) take_write(cyc);
            if (cyc == 5) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_coll", 64'(collision), 64'd0);
        check("abort_writes", 64'(n_wr), 64'd1);
        clear_model();
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            check("abort_quiet", 64'({fb_we, done}), 64'd0);
        end

        launch(8'd16, 8'd8, 4'd2, 12'hFFF);
        finish_draw(7, 1'b0);
        check("addr_wrap_writes", 64'(n_wr), 64'd2);

        launch(8'd20, 8'd12, 4'd2, 12'h140);
        finish_draw(7, 1'b1);
        check("start_ignored_writes", 64'(n_wr), 64'd2);

        @(negedge clk);
        reset  = 1'b1;
        start  = 1'b1;
        vx     = 8'd0;
        vy     = 8'd0;
        n      = 4'd1;
        i_addr = 12'h100;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        clear_model();
        check("reset_over_start_busy", 64'(busy), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("reset_over_start_quiet", 64'({fb_we, done, busy}), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
